lc3_sequencer: RTL

Parametrised successor to the LC-3 control FSM. Memory wait states are configurable, and all accesses share one generic access state with a return target. A ready/timeout handshake mode, a multi-cycle MUL (opcode 1101) handshake and an edge-triggered single-step mode are added. The block sits between the IR/NZP logic and the datapath muxes/gates, and drives the memory I/O enable.

---
 rtl/lc3_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/lc3_sequencer.sv
// LC-3 control sequencer: one shared memory ACCESS state with a latched return
// target, fixed-count or ready/timeout access, MUL handshake and single-step pause.
module lc3_sequencer #(
    parameter int MEM_WAIT      = 2,
    parameter int USE_MEM_READY = 0,
    parameter int TIMEOUT       = 255
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Run,
    input  logic        Continue,
    input  logic        Step_En,
    input  logic        BEN,
    input  logic [15:0] IR,
    input  logic        Mem_Ready,
    input  logic        Mul_Done,
    output logic [6:0]  Ld,
    output logic [3:0]  Gate,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  PCMUX,
    output logic [1:0]  DRMUX,
    output logic [1:0]  SR1MUX,
    output logic        SR2MUX,
    output logic        MARMUX,
    output logic [1:0]  ALUK,
    output logic        MIO_EN,
    output logic        R_W,
    output logic        Mul_Start,
    output logic        Halted,
    output logic        Paused,
    output logic        Invalid,
    output logic        Timeout,
    output logic [3:0]  Opcode
);
    typedef enum logic [4:0] {
        S_HALT, S_18, S_ACC, S_35, S_PAUSE, S_32,
        S_00, S_01, S_02, S_03, S_04, S_05, S_06, S_07, S_09,
        S_10, S_11, S_12, S_13, S_14, S_15,
        S_20, S_21, S_22, S_23, S_26, S_27, S_30, S_31,
        S_MULW, S_INV, S_FAULT
    } state_t;

    localparam logic [1:0] KIND_READ  = 2'd1;
    localparam logic [1:0] KIND_WRITE = 2'd2;
    localparam logic [7:0] WAIT_LAST  = 8'(MEM_WAIT);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);
    localparam bit         READY_MODE = (USE_MEM_READY != 0);
    localparam int L_MAR = 0, L_MDR = 1, L_IR = 2, L_BEN = 3, L_REG = 4, L_CC = 5, L_PC = 6;
    localparam int G_PC = 0, G_MDR = 1, G_ALU = 2, G_MARMUX = 3;

    state_t     r_state, r_ret, w_next, w_ret;
    logic [1:0] r_kind, w_kind;
    logic [7:0] r_cnt;
    logic       r_cont_q;
    logic       w_cont_rise, w_acc_final, w_acc_fault, w_acc_enter;
    logic       w_unused;

    assign w_cont_rise = Continue & ~r_cont_q;
    assign w_acc_final = READY_MODE ? Mem_Ready : (r_cnt == WAIT_LAST);
    assign w_acc_fault = READY_MODE && !Mem_Ready && (r_cnt >= TO_LAST);
    assign w_acc_enter = (w_next == S_ACC) && (r_state != S_ACC);
    assign Opcode      = IR[15:12];
    assign SR2MUX      = IR[5];
    assign w_unused    = &{1'b0, IR[10:6], IR[4:0]};

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state  <= S_HALT;
            r_ret    <= S_35;
            r_kind   <= KIND_READ;
            r_cnt    <= '0;
            r_cont_q <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cont_q <= Continue;
            if (w_acc_enter) begin
                r_ret  <= w_ret;
                r_kind <= w_kind;
            end
            // counter only runs inside ACCESS and saturates instead of wrapping
            if (r_state != S_ACC)    r_cnt <= '0;
            else if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        w_ret  = S_35;
        w_kind = KIND_READ;
        unique case (r_state)
            S_HALT:  if (Run) w_next = S_18;
            S_18:    w_next = S_ACC;
            S_ACC: begin
                if (w_acc_final)      w_next = (r_kind == KIND_WRITE) ? S_18 : r_ret;
                else if (w_acc_fault) w_next = S_FAULT;
            end
            S_35:    w_next = Step_En ? S_PAUSE : S_32;
            S_PAUSE: if (w_cont_rise) w_next = S_32;
            S_32: begin
                unique case (IR[15:12])
                    4'h0: w_next = S_00;  4'h1: w_next = S_01;
                    4'h2: w_next = S_02;  4'h3: w_next = S_03;
                    4'h4: w_next = S_04;  4'h5: w_next = S_05;
                    4'h6: w_next = S_06;  4'h7: w_next = S_07;
                    4'h8: w_next = S_INV; 4'h9: w_next = S_09;
                    4'hA: w_next = S_10;  4'hB: w_next = S_11;
                    4'hC: w_next = S_12;  4'hD: w_next = S_13;
                    4'hE: w_next = S_14;  default: w_next = S_15;
                endcase
            end
            S_00:       w_next = BEN ? S_22 : S_18;
            S_02, S_06: begin w_next = S_ACC; w_ret = S_27; end
            S_10:       begin w_next = S_ACC; w_ret = S_26; end
            S_26:       begin w_next = S_ACC; w_ret = S_27; end
            S_11:       begin w_next = S_ACC; w_ret = S_31; end
            S_15:       begin w_next = S_ACC; w_ret = S_30; end
            S_23:       begin w_next = S_ACC; w_ret = S_18; w_kind = KIND_WRITE; end
            S_03, S_07, S_31: w_next = S_23;
            S_04:       w_next = IR[11] ? S_21 : S_20;
            S_13:       w_next = S_MULW;
            S_MULW:     if (Mul_Done) w_next = S_18;
            S_INV, S_FAULT: if (w_cont_rise) w_next = S_HALT;
            default:    w_next = S_18;
        endcase
    end

    always_comb begin
        Ld = '0; Gate = '0; ADDR1MUX = 1'b0; ADDR2MUX = '0; PCMUX = '0;
        DRMUX = '0; SR1MUX = '0; MARMUX = 1'b0; ALUK = '0;
        MIO_EN = 1'b0; R_W = 1'b0; Mul_Start = 1'b0;
        Halted  = (r_state == S_HALT);
        Paused  = (r_state == S_PAUSE);
        Invalid = (r_state == S_INV);
        Timeout = (r_state == S_FAULT);
        unique case (r_state)
            S_18:  begin Gate[G_PC] = 1'b1; Ld[L_MAR] = 1'b1; Ld[L_PC] = 1'b1; end
            S_ACC: begin
                MIO_EN     = 1'b1;
                R_W        = (r_kind == KIND_WRITE);
                Ld[L_MDR]  = (r_kind == KIND_READ) && w_acc_final;
            end
            S_35:  begin Gate[G_MDR] = 1'b1; Ld[L_IR] = 1'b1; end
            S_32:  Ld[L_BEN] = 1'b1;
            S_01, S_05, S_09: begin
                SR1MUX = 2'b01; Gate[G_ALU] = 1'b1; Ld[L_REG] = 1'b1; Ld[L_CC] = 1'b1;
                ALUK   = (r_state == S_01) ? 2'b00 : (r_state == S_05) ? 2'b01 : 2'b10;
            end
            S_02, S_03, S_10, S_11: begin
                ADDR2MUX = 2'b10; MARMUX = 1'b1; Gate[G_MARMUX] = 1'b1; Ld[L_MAR] = 1'b1;
            end
            S_06, S_07: begin
                ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; SR1MUX = 2'b01;
                MARMUX = 1'b1; Gate[G_MARMUX] = 1'b1; Ld[L_MAR] = 1'b1;
            end
            S_26, S_31: begin Gate[G_MDR] = 1'b1; Ld[L_MAR] = 1'b1; end
            S_27:  begin Gate[G_MDR] = 1'b1; Ld[L_REG] = 1'b1; Ld[L_CC] = 1'b1; end
            S_23:  begin SR1MUX = 2'b00; ALUK = 2'b11; Gate[G_ALU] = 1'b1; Ld[L_MDR] = 1'b1; end
            S_15:  begin Gate[G_MARMUX] = 1'b1; Ld[L_MAR] = 1'b1; end
            S_30:  begin Gate[G_MDR] = 1'b1; Ld[L_PC] = 1'b1; PCMUX = 2'b01; end
            S_22:  begin ADDR2MUX = 2'b10; PCMUX = 2'b10; Ld[L_PC] = 1'b1; end
            S_04:  begin Gate[G_PC] = 1'b1; Ld[L_REG] = 1'b1; DRMUX = 2'b01; end
            S_21:  begin ADDR2MUX = 2'b11; PCMUX = 2'b10; Ld[L_PC] = 1'b1; end
            S_20, S_12: begin
                SR1MUX = 2'b01; ADDR1MUX = 1'b1; PCMUX = 2'b10; Ld[L_PC] = 1'b1;
            end
            S_14:  begin
                ADDR2MUX = 2'b10; MARMUX = 1'b1; Gate[G_MARMUX] = 1'b1;
                Ld[L_REG] = 1'b1; Ld[L_CC] = 1'b1;
            end
            S_13:  Mul_Start = 1'b1;
            S_MULW: if (Mul_Done) begin
                Gate[G_ALU] = 1'b1; Ld[L_REG] = 1'b1; Ld[L_CC] = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
